// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings,
// sequencer states and fixed result constants.
package hilo_pkg;

    localparam int HILO_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // LO value produced by a divide with a zero divisor
    localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        WB   = 2'd3
    } state_t;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_muldiv_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply and restoring divide on
// unsigned magnitudes, one bit per step_i cycle.
module muldiv_iter_core
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    // hi: product accumulator / partial remainder
    // lo: multiplier shifting out / dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_ok;

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        shifted  = {hi_q, lo_q[WIDTH-1]};
        sub_ok   = shifted >= {1'b0, b_q};
        // when sub_ok the true difference is below b_q, so WIDTH bits suffice
        sub_diff = shifted[WIDTH-1:0] - b_q;

        if (load_i) begin
            hi_d = '0;
            lo_d = a_i;
            b_d  = b_i;
        end else if (step_i) begin
            if (div_mode_i) begin
                hi_d = sub_ok ? sub_diff : shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], sub_ok};
            end else begin
                hi_d = add_sum[WIDTH:1];
                lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO write sequencer: MULT/MULTU/DIV/DIVU/MTHI/MTLO with registered write pulses.
// Optional HILO_FAST_ZERO_EN: zero-operand multiplies and DIVU with rs<rt finish in one cycle.
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_in,
    output logic [WIDTH-1:0] lo_in,
    output logic             hi_w,
    output logic             lo_w
);

    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic             wr_hi_q, wr_hi_d;
    logic             wr_lo_q, wr_lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hi_w_q, hi_w_d;
    logic             lo_w_q, lo_w_d;
    logic [WIDTH-1:0] hi_in_q, hi_in_d;
    logic [WIDTH-1:0] lo_in_q, lo_in_d;

    logic             core_load, core_step;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic             op_signed;
    logic             fast_mul, fast_divu;
    logic [2*WIDTH-1:0] prod_mag, prod_neg;

`ifdef HILO_FAST_ZERO_EN
    assign fast_mul  = (rs_val == '0) || (rt_val == '0);
    assign fast_divu = rs_val < rt_val;
`else
    assign fast_mul  = 1'b0;
    assign fast_divu = 1'b0;
`endif

    assign op_signed = is_signed_op(op);
    assign rs_mag    = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rt_mag    = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    assign prod_mag  = {core_hi, core_lo};
    assign prod_neg  = -prod_mag;

    muldiv_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .load_i     (core_load),
        .step_i     (core_step),
        .div_mode_i (is_div_q),
        .a_i        (rs_mag),
        .b_i        (rt_mag),
        .hi_o       (core_hi),
        .lo_o       (core_lo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        wr_hi_d   = wr_hi_q;
        wr_lo_d   = wr_lo_q;
        busy_d    = (state_q != IDLE);
        done_d    = 1'b0;
        hi_w_d    = 1'b0;
        lo_w_d    = 1'b0;
        hi_in_d   = hi_in_q;
        lo_in_d   = lo_in_q;
        core_load = 1'b0;
        core_step = 1'b0;

        case (state_q)
            IDLE: begin
                // busy_q still covers the WB output cycle after the state returns here
                if (start && !busy_q) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            wr_hi_d = 1'b1;
                            wr_lo_d = 1'b1;
                            if (fast_mul) begin
                                res_hi_d = '0;
                                res_lo_d = '0;
                                state_d  = WB;
                            end else begin
                                core_load = 1'b1;
                                is_div_d  = 1'b0;
                                q_neg_d   = op_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                                r_neg_d   = 1'b0;
                                cnt_d     = '0;
                                state_d   = CALC;
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            wr_hi_d = 1'b1;
                            wr_lo_d = 1'b1;
                            if (rt_val == '0) begin
                                res_hi_d = rs_val;
                                res_lo_d = WIDTH'(DIVZERO_LO);
                                state_d  = WB;
                            end else if (op == OP_DIVU && fast_divu) begin
                                res_hi_d = rs_val;
                                res_lo_d = '0;
                                state_d  = WB;
                            end else begin
                                core_load = 1'b1;
                                is_div_d  = 1'b1;
                                q_neg_d   = op_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                                r_neg_d   = op_signed & rs_val[WIDTH-1];
                                cnt_d     = '0;
                                state_d   = CALC;
                            end
                        end
                        OP_MTHI: begin
                            res_hi_d = rs_val;
                            wr_hi_d  = 1'b1;
                            wr_lo_d  = 1'b0;
                            state_d  = WB;
                        end
                        OP_MTLO: begin
                            res_lo_d = rs_val;
                            wr_hi_d  = 1'b0;
                            wr_lo_d  = 1'b1;
                            state_d  = WB;
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                core_step = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    cnt_d   = '0;
                    state_d = SIGN;
                end
            end
            SIGN: begin
                if (is_div_q) begin
                    res_hi_d = r_neg_q ? -core_hi : core_hi;
                    res_lo_d = q_neg_q ? -core_lo : core_lo;
                end else begin
                    {res_hi_d, res_lo_d} = q_neg_q ? prod_neg : prod_mag;
                end
                state_d = WB;
            end
            WB: begin
                done_d  = 1'b1;
                hi_w_d  = wr_hi_q;
                lo_w_d  = wr_lo_q;
                hi_in_d = wr_hi_q ? res_hi_q : hi_in_q;
                lo_in_d = wr_lo_q ? res_lo_q : lo_in_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            wr_hi_q  <= 1'b0;
            wr_lo_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_w_q   <= 1'b0;
            lo_w_q   <= 1'b0;
            hi_in_q  <= '0;
            lo_in_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            wr_hi_q  <= wr_hi_d;
            wr_lo_q  <= wr_lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_w_q   <= hi_w_d;
            lo_w_q   <= lo_w_d;
            hi_in_q  <= hi_in_d;
            lo_in_q  <= lo_in_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign hi_w  = hi_w_q;
    assign lo_w  = lo_w_q;
    assign hi_in = hi_in_q;
    assign lo_in = lo_in_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed + randomized bench for hilo_muldiv_ctrl against an arithmetic HI/LO model.
module tb_hilo_muldiv_ctrl;

    localparam logic [2:0] T_MULT  = 3'd0;
    localparam logic [2:0] T_MULTU = 3'd1;
    localparam logic [2:0] T_DIV   = 3'd2;
    localparam logic [2:0] T_DIVU  = 3'd3;
    localparam logic [2:0] T_MTHI  = 3'd4;
    localparam logic [2:0] T_MTLO  = 3'd5;
    localparam int FULL_LAT = 34;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, done, hi_w, lo_w;
    logic [31:0] hi_in, lo_in;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    hilo_muldiv_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi_in  (hi_in),
        .lo_in  (lo_in),
        .hi_w   (hi_w),
        .lo_w   (lo_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, then follow it cycle by cycle; inj>0 raises a stray DIV start at that cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj);
        logic [31:0] eh, el;
        logic        ewh, ewl;
        int          lat;
        logic [63:0] p;
        longint      sq, sr;
        eh = m_hi; el = m_lo; ewh = 1'b1; ewl = 1'b1; lat = FULL_LAT;
        case (o)
            T_MULT: begin
                sq = longint'($signed(a)) * longint'($signed(b));
                p = sq; eh = p[63:32]; el = p[31:0];
`ifdef HILO_FAST_ZERO_EN
                if (a == 0 || b == 0) lat = 1;
`endif
            end
            T_MULTU: begin
                p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0];
`ifdef HILO_FAST_ZERO_EN
                if (a == 0 || b == 0) lat = 1;
`endif
            end
            T_DIV: begin
                if (b == 0) begin
                    eh = a; el = 32'hFFFF_FFFF; lat = 1;
                end else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    p = sq; el = p[31:0];
                    p = sr; eh = p[31:0];
                end
            end
            T_DIVU: begin
                if (b == 0) begin
                    eh = a; el = 32'hFFFF_FFFF; lat = 1;
                end else begin
                    el = a / b; eh = a % b;
`ifdef HILO_FAST_ZERO_EN
                    if (a < b) lat = 1;
`endif
                end
            end
            T_MTHI: begin eh = a; ewl = 1'b0; lat = 1; end
            default: begin el = a; ewh = 1'b0; lat = 1; end
        endcase

        op = o; rs_val = a; rt_val = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k < lat) begin
                check("busy_run", {busy, done, hi_w, lo_w}, 4'b1000);
            end else begin
                check("wb_flags", {busy, done, hi_w, lo_w}, {2'b11, ewh, ewl});
                check("hi_in", hi_in, eh);
                check("lo_in", lo_in, el);
                $display("[TB] op=%0d rs=%h rt=%h lat=%0d -> hi=%h lo=%h", o, a, b, k, hi_in, lo_in);
            end
            if (k == inj) begin
                start = 1'b1; op = T_DIV; rs_val = $urandom; rt_val = $urandom;
            end
        end
        start = 1'b0;
        m_hi = eh; m_lo = el;
        @(posedge clk); #1;
        check("post_wb", {busy, done, hi_w, lo_w}, 4'b0000);
        check("hold_hi", hi_in, eh);
        check("hold_lo", lo_in, el);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          sel;

        rst = 1'b1; start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", {busy, done, hi_w, lo_w}, 4'b0000);
        check("reset_hi", hi_in, 32'd0);
        check("reset_lo", lo_in, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(T_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(T_MULT,  32'hFFFF_FFFD, 32'd7, 0);
        run_op(T_DIV,   32'hFFFF_FFF9, 32'd2, 0);
        run_op(T_DIVU,  32'd100, 32'd7, 0);
        run_op(T_DIVU,  32'd5, 32'd0, 0);
        run_op(T_MTHI,  32'h0000_1234, 32'd0, 0);
        run_op(T_MTLO,  32'hCAFE_0001, 32'd9, 0);
        run_op(T_MULT,  32'h8000_0001, 32'h7FFF_FFF3, 5);
        run_op(T_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(T_DIV,   32'd7, 32'hFFFF_FFFE, 0);
        run_op(T_MULTU, 32'h1234_5678, 32'd0, 0);
        run_op(T_DIVU,  32'd3, 32'd1000, 0);
        run_op(T_DIV,   32'd10, 32'd0, 0);

        // NOP ops must be ignored
        op = 3'd6; start = 1'b1; rs_val = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        op = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("nop_idle", {busy, done, hi_w, lo_w, hi_in, lo_in}, {4'b0000, m_hi, m_lo});
        end

        // Reset mid-multiply: no write pulse, outputs cleared
        op = T_MULT; rs_val = 32'd1234; rt_val = 32'd5678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_abort_flags", {busy, done, hi_w, lo_w}, 4'b0000);
        check("rst_abort_hi", hi_in, 32'd0);
        check("rst_abort_lo", lo_in, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            check("rst_no_pulse", {busy, done, hi_w, lo_w}, 4'b0000);
        end
        run_op(T_MTLO, 32'h0BAD_F00D, 32'd0, 0);

        for (int i = 0; i < 24; i++) begin
            ro  = 3'($urandom_range(0, 5));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = 32'd0;
                1: ra = 32'd0;
                2: begin ra = $urandom_range(0, 50); rb = $urandom_range(51, 1000); end
                3: ra = 32'h8000_0000;
                4: rb = $urandom_range(1, 9);
                default: ;
            endcase
            run_op(ro, ra, rb, (sel == 5) ? 3 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
